// File: rtl/conv_relu_bram_if.sv
// conv_relu_bram_if
//   Groups the control/load/readback signals of conv_relu_bram.
//   master : the side that loads the image, starts a run and reads results
//   slave  : the convolution engine itself
//   Signals:
//     start      - level request to begin a run (honoured in IDLE or DONE)
//     load_en    - image memory write strobe
//     load_addr  - image write address, row-major r*IMG_W+c
//     load_data  - unsigned 8-bit pixel
//     infer_addr - result read address, row-major r*OUT_W+c
//     infer_dout - result read data, one cycle after infer_addr
//     done       - high once the whole output map is written
//     curr_state - current FSM state encoding
interface conv_relu_bram_if;
    logic        start;
    logic        load_en;
    logic [15:0] load_addr;
    logic [7:0]  load_data;
    logic [15:0] infer_addr;
    logic [7:0]  infer_dout;
    logic        done;
    logic [3:0]  curr_state;

    modport master (
        output start, load_en, load_addr, load_data, infer_addr,
        input  infer_dout, done, curr_state
    );

    modport slave (
        input  start, load_en, load_addr, load_data, infer_addr,
        output infer_dout, done, curr_state
    );
endinterface

// File: rtl/conv_relu_bram.sv
// conv_relu_bram
//   Sequential KxK convolution over an IMG_W x IMG_W unsigned 8-bit image held
//   in an internal block RAM, followed by ReLU and saturation to 8 bits. Each
//   output pixel is produced by a READ/WAIT/ACC loop per tap (one multiply per
//   tap) then WRITE and NEXT, so every output pixel costs 3*K*K+2 cycles.
//   Ports:
//     clk   - clock, all state changes on posedge
//     rst_n - asynchronous active-low reset (control, accumulator, readback)
//     bus   - conv_relu_bram_if.slave: image load port, start/done handshake,
//             result readback port and current state
module conv_relu_bram #(
    parameter int                 IMG_W  = 9,
    parameter int                 K      = 3,
    parameter logic [8*K*K-1:0]   KERNEL = {(K*K){8'h01}},
    parameter int                 SHIFT  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    conv_relu_bram_if.slave        bus
);
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int ACC_W  = 20;
    localparam int OUT_W  = IMG_W - K + 1;
    localparam int IMG_N  = IMG_W * IMG_W;
    localparam int OUT_N  = OUT_W * OUT_W;
    localparam int TAPS   = K * K;
    localparam int IA_W   = $clog2(IMG_N);
    localparam int RA_W   = $clog2(OUT_N);
    localparam int XY_W   = $clog2(OUT_W + 1);
    localparam int T_W    = $clog2(K + 1);
    localparam int TAP_W  = $clog2(TAPS + 1);

    localparam logic [15:0]             IMG_N16  = 16'(IMG_N);
    localparam logic [15:0]             OUT_N16  = 16'(OUT_N);
    localparam logic [XY_W-1:0]         XY_LAST  = XY_W'(OUT_W - 1);
    localparam logic [T_W-1:0]          T_LAST   = T_W'(K - 1);
    localparam logic [TAP_W-1:0]        TAP_LAST = TAP_W'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(255);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_READ  = 4'd1,
        S_WAIT  = 4'd2,
        S_ACC   = 4'd3,
        S_WRITE = 4'd4,
        S_NEXT  = 4'd5,
        S_DONE  = 4'd6
    } state_t;

    state_t                     state;
    logic [XY_W-1:0]            ox, oy;
    logic [T_W-1:0]             tx, ty;
    logic [TAP_W-1:0]           tap;
    logic signed [ACC_W-1:0]    acc;
    logic                       done_q;
    logic [DATA_W-1:0]          dout_q;

    logic [DATA_W-1:0]          img_mem [IMG_N];
    logic [DATA_W-1:0]          res_mem [OUT_N];
    logic [DATA_W-1:0]          pix_p0;

    logic [IA_W-1:0]            img_rd_addr;
    logic [RA_W-1:0]            res_wr_addr;
    logic signed [COEF_W-1:0]   weight;
    logic                       load_ok;
    logic                       infer_ok;
    logic                       idle_or_done;

    // Zero-extended pixel times signed weight, sign-extended to accumulator width.
    function automatic logic signed [ACC_W-1:0] mac_term(
        input logic [DATA_W-1:0]        pix,
        input logic signed [COEF_W-1:0] w
    );
        logic signed [DATA_W:0]          px_s;
        logic signed [DATA_W+COEF_W:0]   prod;
        px_s = signed'({1'b0, pix});
        prod = px_s * w;
        return ACC_W'(prod);
    endfunction

    // Scale, then ReLU (negative -> 0) and saturate to the 8-bit output range.
    function automatic logic [DATA_W-1:0] relu_clamp(
        input logic signed [ACC_W-1:0] a
    );
        logic signed [ACC_W-1:0] s;
        s = a >>> SHIFT;
        if (s[ACC_W-1])
            return '0;
        else if (s > SAT_MAX)
            return '1;
        else
            return DATA_W'(s);
    endfunction

    always_comb begin
        img_rd_addr  = IA_W'((int'(oy) + int'(ty)) * IMG_W + int'(ox) + int'(tx));
        res_wr_addr  = RA_W'(int'(oy) * OUT_W + int'(ox));
        weight       = KERNEL[int'(tap) * COEF_W +: COEF_W];
        idle_or_done = (state == S_IDLE) || (state == S_DONE);
        load_ok      = bus.load_en && idle_or_done && (bus.load_addr < IMG_N16);
        infer_ok     = (state == S_DONE) && !bus.start && (bus.infer_addr < OUT_N16);
    end

    // Image RAM: host writes only while idle; the engine reads one tap per READ.
    always_ff @(posedge clk) begin
        if (load_ok)
            img_mem[bus.load_addr[IA_W-1:0]] <= bus.load_data;
        if (state == S_READ)
            pix_p0 <= img_mem[img_rd_addr];
    end

    // Result RAM: one write per output pixel; survives reset by design.
    always_ff @(posedge clk) begin
        if (state == S_WRITE)
            res_mem[res_wr_addr] <= relu_clamp(acc);
    end

    // Control FSM, window/tap counters and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            ox     <= '0;
            oy     <= '0;
            tx     <= '0;
            ty     <= '0;
            tap    <= '0;
            acc    <= '0;
            done_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state  <= S_READ;
                        ox     <= '0;
                        oy     <= '0;
                        tx     <= '0;
                        ty     <= '0;
                        tap    <= '0;
                        acc    <= '0;
                        done_q <= 1'b0;
                    end
                end
                S_READ:  state <= S_WAIT;
                S_WAIT:  state <= S_ACC;
                S_ACC: begin
                    acc <= acc + mac_term(pix_p0, weight);
                    if (tap == TAP_LAST) begin
                        state <= S_WRITE;
                    end else begin
                        tap <= tap + 1'b1;
                        if (tx == T_LAST) begin
                            tx <= '0;
                            ty <= ty + 1'b1;
                        end else begin
                            tx <= tx + 1'b1;
                        end
                        state <= S_READ;
                    end
                end
                S_WRITE: state <= S_NEXT;
                S_NEXT: begin
                    acc <= '0;
                    tap <= '0;
                    tx  <= '0;
                    ty  <= '0;
                    if (ox != XY_LAST) begin
                        ox    <= ox + 1'b1;
                        state <= S_READ;
                    end else begin
                        ox <= '0;
                        if (oy != XY_LAST) begin
                            oy    <= oy + 1'b1;
                            state <= S_READ;
                        end else begin
                            oy     <= '0;
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Readback: zero outside DONE (and on the edge that leaves DONE) or out of range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dout_q <= '0;
        else if (infer_ok)
            dout_q <= res_mem[bus.infer_addr[RA_W-1:0]];
        else
            dout_q <= '0;
    end

    assign bus.done       = done_q;
    assign bus.curr_state = state;
    assign bus.infer_dout = dout_q;

endmodule

// File: doc/conv_relu_bram.md
CONV_RELU_BRAM -- requirements
Module: conv_relu_bram

Interface
REQ-001 SHALL have parameter IMG_W, default 9, meaning input image width/height in pixels (square).
REQ-002 SHALL have parameter K, default 3, meaning kernel width/height; output width OUT_W = IMG_W-K+1 (default 7, 49 pixels), stride 1.
REQ-003 SHALL have parameter KERNEL, width 8*K*K, default all 8'sd1, meaning signed 8-bit weights with tap (r,c) at bits [(r*K+c)*8 +: 8].
REQ-004 SHALL have parameter SHIFT, default 0, meaning arithmetic right shift applied to the accumulator before clamping.
REQ-005 clk  input  1  single clock; all state changes on posedge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  level; sampled in IDLE or DONE to begin a run.
REQ-008 load_en  input  1  write strobe for the input image memory.
REQ-009 load_addr  input  16  input image address, row-major (r*IMG_W+c).
REQ-010 load_data  input  8  unsigned input pixel.
REQ-011 infer_addr  input  16  output memory read address, row-major (r*OUT_W+c).
REQ-012 infer_dout  output  8  output memory read data.
REQ-013 done  output  1  registered; high when the full output map is written.
REQ-014 curr_state  output  4  registered copy of the FSM state encoding.

Function
REQ-015 SHALL contain two internal synchronous-read memories: image (IMG_W*IMG_W x 8) and result (OUT_W*OUT_W x 8), each with 1-cycle read latency; memory contents are not cleared by reset.
REQ-016 SHALL write load_data to image[load_addr] on a clock edge with load_en=1 only in IDLE or DONE and only when load_addr < IMG_W*IMG_W; all other loads are ignored.
REQ-017 SHALL use states IDLE=0, READ=1, WAIT=2, ACC=3, WRITE=4, NEXT=5, DONE=6; curr_state equals the current state.
REQ-018 IDLE: start=1 -> READ with window origin (0,0), tap index 0, accumulator 0, done 0.
REQ-019 READ: issue image read at (oy+ty)*IMG_W + (ox+tx); -> WAIT.
REQ-020 WAIT: -> ACC.
REQ-021 ACC: accumulator += signed(pixel zero-extended) * weight(ty,tx); if tap is last (K*K-1) -> WRITE, else advance tx (wrap to 0 and increment ty at K-1) -> READ.
REQ-022 Accumulator SHALL be signed, at least 20 bits; no overflow for any 8-bit inputs with K=3.
REQ-023 WRITE: result[oy*OUT_W+ox] <= clamp(acc >>> SHIFT) where negative -> 0 (ReLU) and >255 -> 255; -> NEXT.
REQ-024 NEXT: clear accumulator and tap; if ox<OUT_W-1 then ox+1; else ox=0 and if oy<OUT_W-1 then oy+1; else -> DONE with done<=1; otherwise -> READ.
REQ-025 Per output pixel SHALL take exactly 3*K*K+2 cycles (29 default); if start is sampled at edge N, done SHALL rise at edge N+OUT_W*OUT_W*(3*K*K+2) (N+1421 default).
REQ-026 DONE: done held 1; infer_dout = result[infer_addr] one cycle after infer_addr is presented; start=1 -> clears done, restarts at READ from origin (0,0).
REQ-027 start SHALL be ignored in READ, WAIT, ACC, WRITE, NEXT.
REQ-028 infer_addr out of range SHALL return 0; infer_dout SHALL be 0 outside DONE.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, curr_state 0, done 0, infer_dout 0, counters and accumulator 0.
REQ-030 Reset mid-run SHALL abandon the run; partially written result entries remain; a subsequent start recomputes all 49 entries.

Verification
REQ-031 Image all 1, default KERNEL -> every result = 9; done at exactly N+1421.
REQ-032 Image pixel = r*9+c, KERNEL center 1 others 0 -> result(r,c) = (r+1)*9+(c+1), e.g. result[0]=10, result[48]=70.
REQ-033 Image all 200, KERNEL all -1 -> every result 0 (ReLU); all 255 with KERNEL all 127 -> every result 255 (saturation).
REQ-034 Pulse start at cycle N+300 while running -> no effect, done still at N+1421; load_en during run -> image unchanged.
REQ-035 rst_n low at cycle N+500 -> curr_state 0, done 0 same cycle; restart -> correct full map and done 1421 cycles after start.
REQ-036 In DONE, sweep infer_addr 0..48 then 49 -> data appears one cycle later; address 49 returns 0.
